// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor, status register, framing FSM.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx_periph #(
  parameter int CLK_DIV_DEFAULT = 868,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx
);

  // state    | meaning
  // S_IDLE   | line high, waiting for a FIFO byte
  // S_START  | start bit (0)
  // S_DATA   | 8 data bits, LSB first
  // S_PARITY | even parity bit (parity builds only)
  // S_STOP   | stop bit (1); may chain straight into the next START
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic [15:0] div_reg, div_lat, cnt;
  logic [2:0]  state, bit_idx;
  logic [7:0]  shift, head;
  logic        par, tx, overflow, busy, bit_end;
  logic        wr_tx, wr_div, rd_any, rd_stat, pop, push, ovf_evt;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign unused_wdata = ^i_wdata[31:16];

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign busy    = (state != S_IDLE);
  assign bit_end = (cnt == 16'd0);

  assign wr_tx   = i_sel && i_we && (i_addr == 4'h0);
  assign wr_div  = i_sel && i_we && (i_addr == 4'h8);
  assign rd_any  = i_sel && !i_we;
  assign rd_stat = rd_any && (i_addr == 4'h4);

  // A frame starts from IDLE, or directly at the end of STOP so frames chain without a gap.
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push    = wr_tx && (!full || pop);
  assign ovf_evt = wr_tx && full && !pop;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_wdata[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_reg  <= CLK_DIV_DEFAULT[15:0];
      overflow <= 1'b0;
      rdata    <= '0;
    end else begin
      if (wr_div) div_reg <= (i_wdata[15:0] == 16'd0) ? 16'd1 : i_wdata[15:0];
      if (ovf_evt)      overflow <= 1'b1;
      else if (rd_stat) overflow <= 1'b0;
      if (rd_any) begin
        case (i_addr)
          4'h4:    rdata <= {28'd0, overflow, busy, empty, full};
          4'h8:    rdata <= {16'd0, div_reg};
          default: rdata <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      div_lat <= CLK_DIV_DEFAULT[15:0];
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else if (pop) begin
      state   <= S_START;
      tx      <= 1'b0;
      shift   <= head;
      par     <= ^head;
      div_lat <= div_reg;
      cnt     <= div_reg - 16'd1;
    end else begin
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx      <= shift[0];
            bit_idx <= '0;
            cnt     <= div_lat - 16'd1;
          end else cnt <= cnt - 16'd1;
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else cnt <= cnt - 16'd1;
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
            cnt   <= div_lat - 16'd1;
          end else cnt <= cnt - 16'd1;
        end
        S_STOP: begin
          if (bit_end) state <= S_IDLE;
          else         cnt   <= cnt - 16'd1;
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx    = tx;
  assign o_rdata = rdata;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed self-checking bench for uart_tx_periph; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_periph;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 11;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 10;
`endif

  logic        clk = 1'b0;
  logic        rst, sel, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        tx;

  int checks = 0;
  int failures = 0;

  // Frame decoder on the line, sampling mid-bit with the divisor the stimulus programmed.
  int         mon_div = 868;
  int         frame_err = 0;
  logic [7:0] rxq [$];

  uart_tx_periph #(.CLK_DIV_DEFAULT(868), .FIFO_DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_tx(tx)
  );

  always #5 clk = ~clk;

  always begin
    logic [10:0] fb;
    @(negedge clk);
    if (tx === 1'b0) begin
      fb = '1;
      for (int b = 0; b < NB; b++) begin
        for (int c = 0; c < mon_div; c++) begin
          if (c == mon_div / 2) fb[b] = tx;
          if (!(b == NB - 1 && c == mon_div - 1)) @(negedge clk);
        end
      end
      if (fb[0] !== 1'b0 || fb[NB-1] !== 1'b1) frame_err++;
      if (PAR && fb[9] !== ^fb[8:1]) frame_err++;
      rxq.push_back(fb[8:1]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    sel = 1'b0;
    d = rdata;
  endtask

  // Expected line level k cycles after the edge that accepted a byte into an idle, empty FIFO.
  function automatic logic exp_tx(input logic [7:0] b, input int div, input int k);
    int bi;
    bi = (k - 1) / div;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (PAR && bi == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin
    logic [31:0] d;
    logic [7:0]  bytes [10];
    int          lows;

    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_tx", tx, 1);
    end
    chk("reset_rdata", rdata, 0);
    @(negedge clk) rst = 1'b0;

    rd(4'h8, d); chk("div_default", d, 868);
    rd(4'h4, d); chk("status_reset", d, 32'h2);
    rd(4'h0, d); chk("txdata_read", d, 0);
    rd(4'h8, d);
    wr(4'hC, 32'h1234);
    chk("rdata_hold_on_write", rdata, 868);
    rd(4'hC, d); chk("reserved_read", d, 0);
    rd(4'h8, d); chk("reserved_write_ignored", d, 868);
    chk("idle_tx", tx, 1);

    // Single frame, divisor 4
    wr(4'h8, 4); mon_div = 4;
    wr(4'h0, 32'hFFFF_FF55);
    chk("tx_before_start", tx, 1);
    for (int k = 1; k <= NB * 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("f55_k%0d", k), tx, exp_tx(8'h55, 4, k));
    end
    rd(4'h4, d); chk("busy_last_stop", d, 32'h6);
    rd(4'h4, d); chk("busy_dropped", d, 32'h2);

    // Back-to-back frames, divisor 2
    wr(4'h8, 2); mon_div = 2;
    wr(4'h0, 32'h41);
    wr(4'h0, 32'h42);
    for (int k = 2; k <= 2 * NB * 2; k++) begin
      @(posedge clk); #1;
      if (k <= NB * 2) chk($sformatf("b2b_a_k%0d", k), tx, exp_tx(8'h41, 2, k));
      else chk($sformatf("b2b_b_k%0d", k), tx, exp_tx(8'h42, 2, k - NB * 2));
    end
    @(posedge clk); #1;
    chk("b2b_idle", tx, 1);

    // Divisor 0 stores 1
    wr(4'h8, 0); mon_div = 1;
    rd(4'h8, d); chk("div_zero_reads_one", d, 1);
    wr(4'h0, 32'hA3);
    for (int k = 1; k <= NB; k++) begin
      @(posedge clk); #1;
      chk($sformatf("div1_k%0d", k), tx, exp_tx(8'hA3, 1, k));
    end
    repeat (3) @(posedge clk);
    chk("frames_so_far", rxq.size(), 4);
    rxq.delete();

    // FIFO fill and overflow, divisor 100
    wr(4'h8, 100); mon_div = 100;
    for (int i = 0; i < 10; i++) begin
      bytes[i] = 8'(8'h30 + 8'(i * 7));
      wr(4'h0, {24'd0, bytes[i]});
    end
    rd(4'h4, d); chk("status_overflow", d, 32'hD);
    rd(4'h4, d); chk("status_ovf_cleared", d, 32'h5);
    repeat (9 * NB * 100 + 50) @(posedge clk);
    rd(4'h4, d); chk("status_drained", d, 32'h2);
    chk("frame_count", rxq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < rxq.size()) chk($sformatf("rx_byte%0d", i), rxq[i], bytes[i]);
    chk("frame_errors", frame_err, 0);

    // Reset during the third data bit
    wr(4'h8, 4); mon_div = 4;
    wr(4'h0, 32'hF0);
    wr(4'h0, 32'h0F);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_bit", tx, exp_tx(8'hF0, 4, 13));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_abort_tx", tx, 1);
    @(negedge clk) rst = 1'b0;
    rd(4'h4, d); chk("status_after_abort", d, 32'h2);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
